// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// master: stream producer / memory side. slave: the loader itself.
interface program_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader. Receives a framed byte stream (16-bit big-endian
// word count, then 4 bytes per word, MSB first), writes assembled words into
// instruction memory starting at BASE_ADDR, and holds the core in reset until
// a complete, length-valid frame has been written.
// Optional build macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// that must match before the core is released.
module program_loader #(
  parameter int          ADDR_WIDTH = 7,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  program_loader_if.slave     bus,
  output logic                cpu_reset,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  // Where the frame goes once the last data byte (or an empty length) is seen.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_AFTER_DATA = S_CHK;
`else
  localparam state_t S_AFTER_DATA = S_DONE;
`endif

  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  state_t                  state_q;
  logic [15:0]             len_q;
  logic [1:0]              byte_cnt_q;
  logic [ADDR_WIDTH-1:0]   word_idx_q;
  logic [23:0]             word_buf_q;
  logic                    imem_we_q;
  logic [31:0]             imem_addr_q;
  logic [31:0]             imem_wdata_q;
  logic [15:0]             words_loaded_q;

  logic [15:0]             len_full_d;
  logic                    last_word_d;
  logic [31:0]             word_addr_d;

  // Full length as it becomes known on the LEN_LO byte.
  assign len_full_d  = {len_q[15:8], bus.rx_data};
  // The word currently being assembled is the final one of the frame.
  assign last_word_d = ((17'(word_idx_q) + 17'd1) == {1'b0, len_q});
  assign word_addr_d = BASE_ADDR + (32'(word_idx_q) << 2);

  assign busy         = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CHK);
  assign bus.rx_ready = busy;
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERROR);
  assign cpu_reset    = ~done;

  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign words_loaded   = words_loaded_q;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] chk_q;

  // Running XOR of every length and data byte accepted in the current frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_q <= '0;
    end else if (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR) begin
      if (start) chk_q <= '0;
    end else if (bus.rx_valid && state_q != S_CHK) begin
      chk_q <= chk_q ^ bus.rx_data;
    end
  end
`endif

  // Frame sequencing, word assembly and the registered memory write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      byte_cnt_q     <= '0;
      word_idx_q     <= '0;
      word_buf_q     <= '0;
      imem_we_q      <= 1'b0;
      imem_addr_q    <= '0;
      imem_wdata_q   <= '0;
      words_loaded_q <= '0;
    end else begin
      imem_we_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state_q        <= S_LEN_HI;
            byte_cnt_q     <= '0;
            word_idx_q     <= '0;
            words_loaded_q <= '0;
          end
        end
        S_LEN_HI: begin
          if (bus.rx_valid) begin
            len_q[15:8] <= bus.rx_data;
            state_q     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (bus.rx_valid) begin
            len_q[7:0] <= bus.rx_data;
            if (len_full_d == 16'd0)
              state_q <= S_AFTER_DATA;
            else if ({1'b0, len_full_d} > MAX_WORDS)
              state_q <= S_ERROR;
            else
              state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (bus.rx_valid) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              imem_we_q      <= 1'b1;
              imem_addr_q    <= word_addr_d;
              imem_wdata_q   <= {word_buf_q, bus.rx_data};
              words_loaded_q <= words_loaded_q + 16'd1;
              if (last_word_d)
                state_q <= S_AFTER_DATA;
              else
                word_idx_q <= word_idx_q + 1'b1;
            end else begin
              word_buf_q <= {word_buf_q[15:0], bus.rx_data};
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (bus.rx_valid)
            state_q <= (bus.rx_data == chk_q) ? S_DONE : S_ERROR;
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames plus randomized
// frames compared against a frame-level model of the expected writes.
module tb_program_loader;
  localparam int AW = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cpu_reset, busy, done, error;
  logic [15:0] words_loaded;

  program_loader_if bus_if();

  program_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(32'h0)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus_if),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [15:0] wr_wl_q[$];
  logic [7:0]  byte_q[$];
  logic [7:0]  data_q[$];
  logic [31:0] last_addr = 32'h0;
  logic [31:0] last_data = 32'h0;

  // Capture every memory write strobe together with the word count seen with it.
  always @(negedge clk) begin
    if (bus_if.imem_we === 1'b1) begin
      wr_addr_q.push_back(bus_if.imem_addr);
      wr_data_q.push_back(bus_if.imem_wdata);
      wr_wl_q.push_back(words_loaded);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drive byte_q one byte per cycle (optionally with idle gaps).
  task automatic send_bytes(input bit expect_accept, input bit gaps);
    foreach (byte_q[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus_if.rx_valid = 1'b0;
        @(negedge clk);
      end
      if (expect_accept) check("rx_ready", 32'(bus_if.rx_ready), 32'd1);
      bus_if.rx_valid = 1'b1;
      bus_if.rx_data  = byte_q[i];
      @(negedge clk);
    end
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input bit exp_done, input bit exp_err,
                               input logic [15:0] exp_wl);
    check({tag, "_done"},   32'(done),      32'(exp_done));
    check({tag, "_error"},  32'(error),     32'(exp_err));
    check({tag, "_cpurst"}, 32'(cpu_reset), 32'(!exp_done));
    check({tag, "_busy"},   32'(busy),      32'd0);
    check({tag, "_wl"},     32'(words_loaded), 32'(exp_wl));
  endtask

  // Load one frame of n words and compare against the expected write list.
  task automatic run_frame(input int n, input bit use_given, input bit wrong_chk, input bit gaps);
    logic [7:0]  hi, lo, chk;
    logic [31:0] w;
    bit          ok_len, exp_ok;
    int          nw;
    hi = n[15:8];
    lo = n[7:0];
    ok_len = (n <= (1 << AW));
    exp_ok = ok_len;
`ifdef LOADER_CHECKSUM_EN
    exp_ok = ok_len && !wrong_chk;
`endif
    if (!use_given) begin
      data_q.delete();
      if (ok_len)
        for (int i = 0; i < 4 * n; i++) data_q.push_back(8'($urandom_range(0, 255)));
    end
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_wl_q.delete();

    pulse_start();
    check("start_cpurst", 32'(cpu_reset), 32'd1);
    check("start_busy",   32'(busy),      32'd1);
    check("start_wl",     32'(words_loaded), 32'd0);

    chk = hi ^ lo;
    byte_q = {hi, lo};
    if (ok_len) begin
      foreach (data_q[i]) begin
        byte_q.push_back(data_q[i]);
        chk = chk ^ data_q[i];
      end
`ifdef LOADER_CHECKSUM_EN
      byte_q.push_back(wrong_chk ? (chk ^ 8'($urandom_range(1, 255))) : chk);
`endif
    end
    send_bytes(1'b1, gaps);
    if (!ok_len) begin
      byte_q = {8'h12, 8'h34, 8'h56, 8'h78};
      send_bytes(1'b0, 1'b0);
    end
    repeat (3) @(negedge clk);

    nw = ok_len ? n : 0;
    check("wr_count", 32'(wr_addr_q.size()), 32'(nw));
    for (int k = 0; k < nw && k < wr_addr_q.size(); k++) begin
      w = {data_q[4*k], data_q[4*k+1], data_q[4*k+2], data_q[4*k+3]};
      check("wr_addr", wr_addr_q[k], 32'(4 * k));
      check("wr_data", wr_data_q[k], w);
      check("wr_wl",   32'(wr_wl_q[k]), 32'(k + 1));
      last_addr = 32'(4 * k);
      last_data = w;
    end
    check_outputs("end", exp_ok, !exp_ok, 16'(nw));
    check("hold_addr", bus_if.imem_addr,  last_addr);
    check("hold_data", bus_if.imem_wdata, last_data);
    $display("frame n=%0d ok_len=%0d wrong_chk=%0d writes=%0d done=%0d error=%0d",
             n, ok_len, wrong_chk, wr_addr_q.size(), done, error);

    // Stray bytes outside a load must be ignored.
    byte_q = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'h00};
    send_bytes(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("idle_wr_count", 32'(wr_addr_q.size()), 32'(nw));
    check_outputs("idle", exp_ok, !exp_ok, 16'(nw));
  endtask

  initial begin
    int r, n;
    reset = 1'b1;
    start = 1'b0;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: idle after reset
    repeat (10) @(negedge clk);
    check("rst_cpurst", 32'(cpu_reset), 32'd1);
    check("rst_ready",  32'(bus_if.rx_ready), 32'd0);
    check("rst_we",     32'(bus_if.imem_we), 32'd0);
    check("rst_addr",   bus_if.imem_addr, 32'd0);
    check("rst_wdata",  bus_if.imem_wdata, 32'd0);
    check_outputs("rst", 1'b0, 1'b0, 16'd0);
    $display("reset idle cpu_reset=%0d rx_ready=%0d", cpu_reset, bus_if.rx_ready);

    // 2: single word
    data_q = {8'h20, 8'h08, 8'h00, 8'h05};
    run_frame(1, 1'b1, 1'b0, 1'b0);
    check("t2_word", last_data, 32'h20080005);

    // 3: three words back to back
    run_frame(3, 1'b0, 1'b0, 1'b0);

    // 4: oversize length, then recovery; boundary sizes
    run_frame(129, 1'b0, 1'b0, 1'b0);
    run_frame(2, 1'b0, 1'b0, 1'b0);
    run_frame(128, 1'b0, 1'b0, 1'b0);
    run_frame(0, 1'b0, 1'b0, 1'b0);

    // 5: reset mid-load after two data bytes
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_wl_q.delete();
    pulse_start();
    byte_q = {8'h00, 8'h02, 8'hDE, 8'hAD};
    send_bytes(1'b1, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_ready",  32'(bus_if.rx_ready), 32'd0);
    check("mid_rst_we",     32'(bus_if.imem_we), 32'd0);
    check("mid_rst_addr",   bus_if.imem_addr, 32'd0);
    check("mid_rst_wdata",  bus_if.imem_wdata, 32'd0);
    check_outputs("mid_rst", 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    last_addr = 32'h0;
    last_data = 32'h0;
    @(negedge clk);
    check("mid_rst_nowr", 32'(wr_addr_q.size()), 32'd0);
    $display("mid-load reset writes=%0d", wr_addr_q.size());
    run_frame(1, 1'b0, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // 6: checksum pass then fail
    data_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_frame(1, 1'b1, 1'b0, 1'b0);
    data_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_frame(1, 1'b1, 1'b1, 1'b0);
    run_frame(0, 1'b0, 1'b1, 1'b0);
`endif

    // Randomized frames
    for (int it = 0; it < 16; it++) begin
      r = $urandom_range(0, 9);
      if (r < 6)       n = $urandom_range(0, 6);
      else if (r == 6) n = 128;
      else if (r == 7) n = 129;
      else if (r == 8) n = $urandom_range(130, 65535);
      else             n = $urandom_range(7, 20);
      run_frame(n, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
